// File: rtl/fb_pkg.sv
// fb_pkg: shared state encoding and sizing helpers for the frame-buffer write controller.
package fb_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_FS, CAPTURE} state_t;
    function automatic int frame_words(input int words_per_line, input int lines);
        return words_per_line * lines;
    endfunction
    function automatic int cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction
endpackage

// File: rtl/framebuf_write_ctrl_if.sv
// framebuf_write_ctrl_if: capture control, pixel stream and RAM write port, named from the controller's side.
interface framebuf_write_ctrl_if #(parameter int ADDR_W = 18);
    logic i_arm, i_continuous, i_clear_err, i_frame_start, i_frame_end, i_pix_valid;
    logic [31:0] i_pix_data;
    logic o_ram_we;
    logic [ADDR_W-1:0] o_ram_addr;
    logic [31:0] o_ram_data;
    logic o_wr_bank, o_rd_bank, o_busy, o_frame_done, o_short_frame, o_overflow;
    modport master (
        output i_arm, i_continuous, i_clear_err, i_frame_start, i_frame_end, i_pix_valid, i_pix_data,
        input o_ram_we, o_ram_addr, o_ram_data, o_wr_bank, o_rd_bank, o_busy, o_frame_done,
        o_short_frame, o_overflow
    );
    modport slave (
        input i_arm, i_continuous, i_clear_err, i_frame_start, i_frame_end, i_pix_valid, i_pix_data,
        output o_ram_we, o_ram_addr, o_ram_data, o_wr_bank, o_rd_bank, o_busy, o_frame_done,
        o_short_frame, o_overflow
    );
endinterface

// File: rtl/fb_addr_gen.sv
// fb_addr_gen: saturating word counter plus bank-base adder producing the registered RAM address.
module fb_addr_gen
    import fb_pkg::*;
#(
    parameter int FW     = 8,
    parameter int ADDR_W = 4,
    parameter int CW     = cnt_w(FW)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_pre_clr,
    input  logic              i_post_clr,
    input  logic              i_en,
    input  logic              i_bank,
    output logic [CW-1:0]     o_cnt,
    output logic [CW-1:0]     o_cnt_nxt,
    output logic              o_accept,
    output logic              o_over,
    output logic [ADDR_W-1:0] o_addr
);
    logic [CW-1:0]     r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [CW-1:0]     w_cnt_eff;
    // A frame starting this cycle counts from zero, so a coincident pixel lands at word 0.
    assign w_cnt_eff = i_pre_clr ? '0 : r_cnt;
    assign o_accept  = i_en && (w_cnt_eff != CW'(FW));
    assign o_over    = i_en && (w_cnt_eff == CW'(FW));
    assign o_cnt_nxt = w_cnt_eff + CW'(o_accept);
    assign o_cnt     = r_cnt;
    assign o_addr    = r_addr;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_addr <= '0;
        end else begin
            r_cnt <= i_post_clr ? '0 : o_cnt_nxt;
            if (o_accept) r_addr <= ADDR_W'(i_bank ? FW : 0) + ADDR_W'(w_cnt_eff);
        end
    end
endmodule

// File: rtl/framebuf_write_ctrl.sv
// framebuf_write_ctrl: aligns pixel-word capture to frame_start, writes one of two ping-pong banks,
// and hands a bank to the display side only after an exact-length, error-free frame.
module framebuf_write_ctrl
    import fb_pkg::*;
#(
    parameter int WORDS_PER_LINE = 160,
    parameter int LINES          = 480,
    parameter int ADDR_W         = 18
) (
    input logic                  clk,
    input logic                  reset,
    framebuf_write_ctrl_if.slave bus
);
    localparam int FW = frame_words(WORDS_PER_LINE, LINES);
    localparam int CW = cnt_w(FW);
    state_t r_state, w_state_nxt;
    logic r_wr_bank, r_rd_bank, r_frame_done, r_short, r_overflow, r_bad, r_ram_we;
    logic [31:0] r_ram_data;
    logic w_in_cap, w_in_wait, w_start_new, w_end, w_pre_clr, w_post_clr, w_en;
    logic w_accept, w_over, w_bad, w_swap, w_short;
    logic [CW-1:0] w_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0] w_addr;
    assign w_in_cap    = r_state == CAPTURE;
    assign w_in_wait   = r_state == WAIT_FS;
    assign w_start_new = (w_in_cap || w_in_wait) && bus.i_frame_start;
    assign w_end       = w_in_cap && bus.i_frame_end;
    // With frame_end present, a coincident pixel belongs to the closing frame; the counter clears after it.
    assign w_pre_clr   = bus.i_frame_start && (w_in_wait || (w_in_cap && !bus.i_frame_end));
    assign w_post_clr  = w_in_cap && bus.i_frame_start && bus.i_frame_end;
    assign w_en        = bus.i_pix_valid && (w_in_cap || (w_in_wait && bus.i_frame_start));
    assign w_bad       = r_bad || w_over;
    assign w_swap      = w_end && (w_cnt_nxt == CW'(FW)) && !w_bad;
    assign w_short     = (w_end && (w_cnt_nxt < CW'(FW))) ||
                         (w_in_cap && bus.i_frame_start && !bus.i_frame_end && (w_cnt < CW'(FW)));
    fb_addr_gen #(.FW(FW), .ADDR_W(ADDR_W), .CW(CW)) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .i_pre_clr  (w_pre_clr),
        .i_post_clr (w_post_clr),
        .i_en       (w_en),
        .i_bank     (r_wr_bank),
        .o_cnt      (w_cnt),
        .o_cnt_nxt  (w_cnt_nxt),
        .o_accept   (w_accept),
        .o_over     (w_over),
        .o_addr     (w_addr)
    );
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = (bus.i_arm || bus.i_continuous) ? WAIT_FS : IDLE;
            WAIT_FS: w_state_nxt = bus.i_frame_start ? CAPTURE : WAIT_FS;
            CAPTURE: w_state_nxt = !bus.i_frame_end ? CAPTURE :
                                   bus.i_frame_start ? CAPTURE :
                                   bus.i_continuous ? WAIT_FS : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b1;
            r_frame_done <= 1'b0;
            r_short      <= 1'b0;
            r_overflow   <= 1'b0;
            r_bad        <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_data   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= w_swap;
            r_short      <= w_short || (r_short && !bus.i_clear_err);
            r_overflow   <= w_over || (r_overflow && !bus.i_clear_err);
            r_bad        <= w_start_new ? 1'b0 : w_bad;
            r_ram_we     <= w_accept;
            if (w_accept) r_ram_data <= bus.i_pix_data;
            if (w_swap) begin
                r_rd_bank <= r_wr_bank;
                r_wr_bank <= ~r_wr_bank;
            end
        end
    end
    assign bus.o_ram_we      = r_ram_we;
    assign bus.o_ram_addr    = w_addr;
    assign bus.o_ram_data    = r_ram_data;
    assign bus.o_wr_bank     = r_wr_bank;
    assign bus.o_rd_bank     = r_rd_bank;
    assign bus.o_busy        = r_state != IDLE;
    assign bus.o_frame_done  = r_frame_done;
    assign bus.o_short_frame = r_short;
    assign bus.o_overflow    = r_overflow;
endmodule
